// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between the UART receiver/transmitter and the ALU: collects A, B and opcode
// bytes, latches the ALU result and hands it to the transmitter. Optional inter-byte timeout: UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
    parameter int DATA_W         = 8,
    parameter int OP_W           = 6,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_done,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_tx_busy,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [OP_W-1:0]   o_alu_op,
    output logic              o_tx_start,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_busy,
    output logic              o_err,
    output logic              o_ovr
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_B     = 3'd1,
        WAIT_OP    = 3'd2,
        EXEC       = 3'd3,
        SEND       = 3'd4,
        TX_WAIT_HI = 3'd5,
        TX_WAIT_LO = 3'd6
    } state_t;

    localparam int NUM_OPS = 8;
    // ADD, SUB, AND, OR, XOR, NOR, SRA, SRL as full 8-bit codes (bits 7:6 zero)
    localparam logic [8*NUM_OPS-1:0] OP_TABLE = {
        8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02
    };

    state_t            state_reg;
    logic [DATA_W-1:0] alu_a_reg;
    logic [DATA_W-1:0] alu_b_reg;
    logic [OP_W-1:0]   alu_op_reg;
    logic [DATA_W-1:0] tx_data_reg;
    logic              tx_start_reg;
    logic              err_reg;
    logic              ovr_reg;

    logic [NUM_OPS-1:0] op_hit;
    logic               op_valid;
    logic               timeout_hit;

    // The whole received byte is compared, so codes with upper bits set never alias a valid opcode.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_op_match
            assign op_hit[gi] = (i_rx_data == DATA_W'(OP_TABLE[gi*8 +: 8]));
        end
    endgenerate

    assign op_valid = |op_hit;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] timeout_cnt_reg;
    logic             timed_state;

    assign timed_state = (state_reg == WAIT_B) || (state_reg == WAIT_OP) ||
                         (state_reg == TX_WAIT_HI);
    // An arriving byte always wins over an expiring count in the same cycle.
    assign timeout_hit = timed_state && !i_rx_done &&
                         (timeout_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            timeout_cnt_reg <= '0;
        end else if (i_rx_done || !timed_state || timeout_hit) begin
            timeout_cnt_reg <= '0;
        end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= IDLE;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_op_reg   <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            err_reg      <= 1'b0;
            ovr_reg      <= 1'b0;
        end else begin
            tx_start_reg <= 1'b0;
            err_reg      <= 1'b0;
            ovr_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_rx_done) begin
                        alu_a_reg <= i_rx_data;
                        state_reg <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        alu_b_reg <= i_rx_data;
                        state_reg <= WAIT_OP;
                    end else if (timeout_hit) begin
                        err_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        if (op_valid) begin
                            alu_op_reg <= i_rx_data[OP_W-1:0];
                            state_reg  <= EXEC;
                        end else begin
                            err_reg   <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        err_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                EXEC: begin
                    // Operands settled last edge; the ALU output is stable now.
                    ovr_reg     <= i_rx_done;
                    tx_data_reg <= i_alu_result;
                    state_reg   <= SEND;
                end
                SEND: begin
                    ovr_reg <= i_rx_done;
                    if (!i_tx_busy) begin
                        tx_start_reg <= 1'b1;
                        state_reg    <= TX_WAIT_HI;
                    end
                end
                TX_WAIT_HI: begin
                    ovr_reg <= i_rx_done;
                    if (i_tx_busy) begin
                        state_reg <= TX_WAIT_LO;
                    end else if (timeout_hit) begin
                        err_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                TX_WAIT_LO: begin
                    ovr_reg <= i_rx_done;
                    if (!i_tx_busy) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_alu_a    = alu_a_reg;
    assign o_alu_b    = alu_b_reg;
    assign o_alu_op   = alu_op_reg;
    assign o_tx_start = tx_start_reg;
    assign o_tx_data  = tx_data_reg;
    assign o_busy     = (state_reg != IDLE);
    assign o_err      = err_reg;
    assign o_ovr      = ovr_reg;

endmodule
